// File: rtl/amm_arb_2to1.sv
// rtl/amm_arb_2to1.sv - 2:1 Avalon-MM arbiter with in-order read-response routing (option: AMM_ARB_RR_EN selects round-robin)
module amm_arb_2to1 #(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 10,
  parameter int BYTE_CNT    = DATA_WIDTH / 8,
  parameter int MAX_PENDING = 4
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic [ADDR_WIDTH-1:0] m0_address,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_WIDTH-1:0] m0_writedata,
  input  logic [BYTE_CNT-1:0]   m0_byteenable,
  output logic                  m0_waitrequest,
  output logic [DATA_WIDTH-1:0] m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic [ADDR_WIDTH-1:0] m1_address,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_WIDTH-1:0] m1_writedata,
  input  logic [BYTE_CNT-1:0]   m1_byteenable,
  output logic                  m1_waitrequest,
  output logic [DATA_WIDTH-1:0] m1_readdata,
  output logic                  m1_readdatavalid,
  output logic [ADDR_WIDTH-1:0] s_address,
  output logic [DATA_WIDTH-1:0] s_writedata,
  output logic [BYTE_CNT-1:0]   s_byteenable,
  output logic                  s_read,
  output logic                  s_write,
  input  logic                  s_waitrequest,
  input  logic [DATA_WIDTH-1:0] s_readdata,
  input  logic                  s_readdatavalid,
  output logic                  rsp_err
);

  localparam int PW = $clog2(MAX_PENDING);
  localparam logic [PW:0] FULL_CNT = {1'b1, {PW{1'b0}}};
  localparam logic [PW:0] ONE_CNT  = {{PW{1'b0}}, 1'b1};

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t          state_q;
  logic            grant_q;
`ifdef AMM_ARB_RR_EN
  logic            prio_q;     // 1: m1 preferred on the next contested IDLE decision
`endif
  logic [PW:0]     count_q;
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic            id_q [MAX_PENDING];
  logic            rsp_err_q;

  logic                  req0, req1;
  logic                  gnt, gnt_vld;
  logic                  g_read, g_write;
  logic                  fifo_full, fifo_empty;
  logic                  fwd_read, fwd_write;
  logic                  accept, push, pop, head;

  // Grant selection, read throttling and FIFO push/pop decisions
  always_comb begin
    req0    = m0_read | m0_write;
    req1    = m1_read | m1_write;
    gnt     = 1'b0;
    gnt_vld = 1'b0;
    if (state_q == S_HOLD) begin
      // A stalled command keeps its grant until the slave takes it
      gnt     = grant_q;
      gnt_vld = grant_q ? req1 : req0;
    end else begin
      gnt_vld = req0 | req1;
`ifdef AMM_ARB_RR_EN
      gnt     = req1 & (~req0 | prio_q);
`else
      gnt     = req1 & ~req0;
`endif
    end
    g_read     = gnt ? m1_read  : m0_read;
    g_write    = gnt ? m1_write : m0_write;
    fifo_full  = (count_q == FULL_CNT);
    fifo_empty = (count_q == '0);
    // read+write together is a read; a read is held back while the ID FIFO is full
    fwd_read   = gnt_vld & g_read & ~fifo_full & ~srst;
    fwd_write  = gnt_vld & ~g_read & g_write & ~srst;
    accept     = (fwd_read | fwd_write) & ~s_waitrequest;
    push       = fwd_read & ~s_waitrequest;
    pop        = s_readdatavalid & ~fifo_empty & ~srst;
    head       = id_q[rd_ptr_q];
  end

  assign s_address        = gnt ? m1_address    : m0_address;
  assign s_writedata      = gnt ? m1_writedata  : m0_writedata;
  assign s_byteenable     = gnt ? m1_byteenable : m0_byteenable;
  assign s_read           = fwd_read;
  assign s_write          = fwd_write;
  assign m0_waitrequest   = ~(accept & ~gnt);
  assign m1_waitrequest   = ~(accept & gnt);
  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;
  assign m0_readdatavalid = pop & ~head;
  assign m1_readdatavalid = pop & head;
  assign rsp_err          = rsp_err_q;

  // Arbiter state, priority, FIFO pointers/count and sticky response error
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q   <= S_IDLE;
      grant_q   <= 1'b0;
`ifdef AMM_ARB_RR_EN
      prio_q    <= 1'b0;
`endif
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q <= (accept || !gnt_vld) ? S_IDLE : S_HOLD;
      grant_q <= gnt;
`ifdef AMM_ARB_RR_EN
      if (accept) prio_q <= ~gnt;
`endif
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + ONE_CNT;
        2'b01:   count_q <= count_q - ONE_CNT;
        default: count_q <= count_q;
      endcase
      if (s_readdatavalid && fifo_empty) rsp_err_q <= 1'b1;
    end
  end

  // ID storage: records which master issued each outstanding read
  always_ff @(posedge clk) begin
    if (push) id_q[wr_ptr_q] <= gnt;
  end

endmodule

// File: tb/tb_amm_arb_2to1.sv
// tb/tb_amm_arb_2to1.sv - self-checking bench for amm_arb_2to1
module tb_amm_arb_2to1;

`ifdef AMM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam int MAXP = 4;

  logic        clk = 1'b0;
  logic        srst;
  logic [9:0]  m_address   [2];
  logic        m_read      [2];
  logic        m_write     [2];
  logic [63:0] m_writedata [2];
  logic [7:0]  m_be        [2];
  logic        m0_wait, m1_wait, m0_rdv, m1_rdv;
  logic [63:0] m0_rdata, m1_rdata;
  logic [9:0]  s_address;
  logic [63:0] s_writedata;
  logic [7:0]  s_byteenable;
  logic        s_read, s_write;
  logic        s_waitrequest;
  logic [63:0] s_readdata;
  logic        s_readdatavalid;
  logic        rsp_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  amm_arb_2to1 #(.DATA_WIDTH(64), .ADDR_WIDTH(10), .BYTE_CNT(8), .MAX_PENDING(MAXP)) dut (
    .clk(clk), .srst(srst),
    .m0_address(m_address[0]), .m0_read(m_read[0]), .m0_write(m_write[0]),
    .m0_writedata(m_writedata[0]), .m0_byteenable(m_be[0]),
    .m0_waitrequest(m0_wait), .m0_readdata(m0_rdata), .m0_readdatavalid(m0_rdv),
    .m1_address(m_address[1]), .m1_read(m_read[1]), .m1_write(m_write[1]),
    .m1_writedata(m_writedata[1]), .m1_byteenable(m_be[1]),
    .m1_waitrequest(m1_wait), .m1_readdata(m1_rdata), .m1_readdatavalid(m1_rdv),
    .s_address(s_address), .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_read(s_read), .s_write(s_write), .s_waitrequest(s_waitrequest),
    .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid), .rsp_err(rsp_err)
  );

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    for (int n = 0; n < 2; n++) begin
      m_address[n]   = '0;
      m_read[n]      = 1'b0;
      m_write[n]     = 1'b0;
      m_writedata[n] = '0;
      m_be[n]        = 8'hFF;
    end
    s_waitrequest   = 1'b0;
    s_readdata      = '0;
    s_readdatavalid = 1'b0;
  endtask

  task automatic do_reset();
    srst = 1'b1;
    idle_inputs();
    cyc();
    cyc();
    srst = 1'b0;
  endtask

  task automatic test_reset();
    srst = 1'b1;
    idle_inputs();
    m_read[0] = 1'b1;
    m_write[1] = 1'b1;
    s_readdatavalid = 1'b1;
    cyc();
    #1;
    vectors++; if (s_read !== 1'b0) begin miscompares++; $display("FAIL rst_s_read got %b exp 0", s_read); end
    vectors++; if (s_write !== 1'b0) begin miscompares++; $display("FAIL rst_s_write got %b exp 0", s_write); end
    vectors++; if (m0_wait !== 1'b1 || m1_wait !== 1'b1) begin miscompares++; $display("FAIL rst_wait got %b%b exp 11", m0_wait, m1_wait); end
    vectors++; if (m0_rdv !== 1'b0 || m1_rdv !== 1'b0) begin miscompares++; $display("FAIL rst_rdv got %b%b exp 00", m0_rdv, m1_rdv); end
    vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_err got %b exp 0", rsp_err); end
    srst = 1'b0;
    idle_inputs();
    cyc();
    vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_err_after got %b exp 0", rsp_err); end
  endtask

  task automatic test_single_read();
    do_reset();
    m_read[0] = 1'b1;
    m_address[0] = 10'h010;
    #1;
    vectors++; if (s_read !== 1'b1) begin miscompares++; $display("FAIL t1_s_read got %b exp 1", s_read); end
    vectors++; if (s_address !== 10'h010) begin miscompares++; $display("FAIL t1_s_address got %h exp 010", s_address); end
    vectors++; if (m0_wait !== 1'b0 || m1_wait !== 1'b1) begin miscompares++; $display("FAIL t1_wait got %b%b exp 01", m0_wait, m1_wait); end
    cyc();
    idle_inputs();
    cyc();
    cyc();
    s_readdatavalid = 1'b1;
    s_readdata = 64'hA5;
    #1;
    vectors++; if (m0_rdv !== 1'b1) begin miscompares++; $display("FAIL t1_m0_rdv got %b exp 1", m0_rdv); end
    vectors++; if (m0_rdata !== 64'hA5) begin miscompares++; $display("FAIL t1_m0_rdata got %h exp a5", m0_rdata); end
    vectors++; if (m1_rdv !== 1'b0) begin miscompares++; $display("FAIL t1_m1_rdv got %b exp 0", m1_rdv); end
    cyc();
    idle_inputs();
    #1;
    vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL t1_rsp_err got %b exp 0", rsp_err); end
  endtask

  task automatic test_arbitration();
    int ex;
    logic [9:0] exa;
    do_reset();
    m_write[0] = 1'b1; m_address[0] = 10'h100;
    m_write[1] = 1'b1; m_address[1] = 10'h200;
    for (int i = 0; i < 8; i++) begin
      #1;
      ex  = RR ? (i % 2) : 0;
      exa = (ex == 1) ? 10'h200 : 10'h100;
      vectors++; if (s_write !== 1'b1) begin miscompares++; $display("FAIL t2_s_write[%0d] got %b exp 1", i, s_write); end
      vectors++; if (s_address !== exa) begin miscompares++; $display("FAIL t2_s_address[%0d] got %h exp %h", i, s_address, exa); end
      vectors++; if (m0_wait !== (ex == 1) || m1_wait !== (ex == 0)) begin
        miscompares++; $display("FAIL t2_wait[%0d] got %b%b exp %b%b", i, m0_wait, m1_wait, ex == 1, ex == 0);
      end
      cyc();
    end
    m_write[0] = 1'b0;
    #1;
    vectors++; if (m1_wait !== 1'b0) begin miscompares++; $display("FAIL t2_m1_alone got %b exp 0", m1_wait); end
    cyc();
    idle_inputs();
  endtask

  task automatic test_hold();
    do_reset();
    m_write[1] = 1'b1; m_address[1] = 10'h3F0; m_writedata[1] = 64'h1234_5678_9ABC_DEF0;
    for (int c = 0; c < 6; c++) begin
      if (c >= 1) begin m_write[0] = 1'b1; m_address[0] = 10'h055; end
      s_waitrequest = (c < 5);
      #1;
      vectors++; if (s_write !== 1'b1 || s_address !== 10'h3F0 || s_writedata !== 64'h1234_5678_9ABC_DEF0) begin
        miscompares++; $display("FAIL t3_hold_cmd[%0d] got %b %h %h exp 1 3f0 123456789abcdef0", c, s_write, s_address, s_writedata);
      end
      vectors++; if (m0_wait !== 1'b1) begin miscompares++; $display("FAIL t3_m0_wait[%0d] got %b exp 1", c, m0_wait); end
      vectors++; if (m1_wait !== (c < 5)) begin miscompares++; $display("FAIL t3_m1_wait[%0d] got %b exp %b", c, m1_wait, c < 5); end
      cyc();
    end
    m_write[1] = 1'b0;
    s_waitrequest = 1'b0;
    #1;
    vectors++; if (s_address !== 10'h055 || m0_wait !== 1'b0) begin
      miscompares++; $display("FAIL t3_m0_next got %h %b exp 055 0", s_address, m0_wait);
    end
    cyc();
    idle_inputs();
  endtask

  task automatic test_throttle();
    logic exp_id [3];
    exp_id[0] = 1'b0; exp_id[1] = 1'b1; exp_id[2] = 1'b0;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      m_read[k % 2] = 1'b1;
      m_address[k % 2] = 10'(k);
      #1;
      vectors++; if (s_read !== 1'b1 || s_address !== 10'(k)) begin
        miscompares++; $display("FAIL t4_issue[%0d] got %b %h exp 1 %h", k, s_read, s_address, 10'(k));
      end
      cyc();
      m_read[k % 2] = 1'b0;
    end
    m_read[0] = 1'b1;
    m_address[0] = 10'h004;
    for (int c = 0; c < 2; c++) begin
      #1;
      vectors++; if (s_read !== 1'b0 || m0_wait !== 1'b1) begin
        miscompares++; $display("FAIL t4_full[%0d] got s_read=%b wait=%b exp 0 1", c, s_read, m0_wait);
      end
      cyc();
    end
    s_readdatavalid = 1'b1;
    s_readdata = 64'd1;
    #1;
    vectors++; if (m0_rdv !== 1'b1 || m1_rdv !== 1'b0 || m0_rdata !== 64'd1) begin
      miscompares++; $display("FAIL t4_rsp1 got %b%b %h exp 10 1", m0_rdv, m1_rdv, m0_rdata);
    end
    vectors++; if (s_read !== 1'b0 || m0_wait !== 1'b1) begin
      miscompares++; $display("FAIL t4_pop_no_free got s_read=%b wait=%b exp 0 1", s_read, m0_wait);
    end
    cyc();
    s_readdata = 64'd2;
    #1;
    vectors++; if (s_read !== 1'b1 || m0_wait !== 1'b0 || s_address !== 10'h004) begin
      miscompares++; $display("FAIL t4_fifth got %b %b %h exp 1 0 004", s_read, m0_wait, s_address);
    end
    vectors++; if (m1_rdv !== 1'b1 || m0_rdv !== 1'b0 || m1_rdata !== 64'd2) begin
      miscompares++; $display("FAIL t4_rsp2 got %b%b %h exp 01 2", m0_rdv, m1_rdv, m1_rdata);
    end
    cyc();
    m_read[0] = 1'b0;
    for (int r = 0; r < 3; r++) begin
      s_readdata = 64'(r + 3);
      #1;
      vectors++; if (m0_rdv !== !exp_id[r] || m1_rdv !== exp_id[r]) begin
        miscompares++; $display("FAIL t4_rsp%0d got %b%b exp %b%b", r + 3, m0_rdv, m1_rdv, !exp_id[r], exp_id[r]);
      end
      cyc();
    end
    s_readdatavalid = 1'b0;
    #1;
    vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL t4_rsp_err got %b exp 0", rsp_err); end
  endtask

  task automatic test_reset_outstanding();
    do_reset();
    m_read[0] = 1'b1;
    cyc();
    m_read[0] = 1'b0;
    m_read[1] = 1'b1;
    cyc();
    m_read[1] = 1'b0;
    srst = 1'b1;
    cyc();
    srst = 1'b0;
    for (int r = 0; r < 2; r++) begin
      s_readdatavalid = 1'b1;
      s_readdata = 64'hDEAD;
      #1;
      vectors++; if (m0_rdv !== 1'b0 || m1_rdv !== 1'b0) begin
        miscompares++; $display("FAIL t5_late_rdv[%0d] got %b%b exp 00", r, m0_rdv, m1_rdv);
      end
      cyc();
    end
    s_readdatavalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++; if (rsp_err !== 1'b1) begin miscompares++; $display("FAIL t5_rsp_err_sticky[%0d] got %b exp 1", c, rsp_err); end
      cyc();
    end
    srst = 1'b1;
    cyc();
    srst = 1'b0;
    #1;
    vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL t5_rsp_err_clear got %b exp 0", rsp_err); end
    cyc();
  endtask

  // Random traffic against a transaction-level model: per master a pending command,
  // a locked master while stalled, the last winner, and a queue of outstanding read owners.
  task automatic test_random();
    bit act [2];
    int locked, last, cand;
    int q [$];
    bit err, isrd, pres_r, pres_w, acc, e0, e1;
    int kind;
    do_reset();
    act[0] = 1'b0; act[1] = 1'b0;
    locked = -1; last = 1; err = 1'b0;
    for (int cyc_i = 0; cyc_i < 600; cyc_i++) begin
      for (int n = 0; n < 2; n++) begin
        if (!act[n] && $urandom_range(0, 99) < 40) begin
          act[n] = 1'b1;
          kind = $urandom_range(0, 9);
          m_read[n]      = (kind < 5);
          m_write[n]     = (kind >= 4);
          m_address[n]   = 10'($urandom);
          m_writedata[n] = {$urandom, $urandom};
          m_be[n]        = 8'($urandom);
        end else if (!act[n]) begin
          m_read[n] = 1'b0;
          m_write[n] = 1'b0;
        end
      end
      s_waitrequest   = ($urandom_range(0, 99) < 30);
      s_readdatavalid = (q.size() > 0) ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 2);
      s_readdata      = {$urandom, $urandom};
      #1;
      if (locked >= 0)             cand = locked;
      else if (act[0] && act[1])   cand = RR ? ((last == 0) ? 1 : 0) : 0;
      else if (act[0])             cand = 0;
      else if (act[1])             cand = 1;
      else                         cand = -1;
      isrd   = (cand >= 0) && m_read[cand];
      pres_r = (cand >= 0) && isrd && (q.size() < MAXP);
      pres_w = (cand >= 0) && !isrd;
      acc    = (pres_r || pres_w) && !s_waitrequest;
      e0     = s_readdatavalid && (q.size() > 0) && (q[0] == 0);
      e1     = s_readdatavalid && (q.size() > 0) && (q[0] == 1);
      vectors++; if (s_read !== pres_r || s_write !== pres_w) begin
        miscompares++; $display("FAIL rnd_strobe[%0d] got %b%b exp %b%b", cyc_i, s_read, s_write, pres_r, pres_w);
      end
      if (pres_r || pres_w) begin
        vectors++;
        if (s_address !== m_address[cand] || (pres_w && (s_writedata !== m_writedata[cand] || s_byteenable !== m_be[cand]))) begin
          miscompares++; $display("FAIL rnd_cmd[%0d] got %h %h %h exp %h %h %h", cyc_i, s_address, s_writedata, s_byteenable,
                                  m_address[cand], m_writedata[cand], m_be[cand]);
        end
      end
      vectors++; if (m0_wait !== !(acc && cand == 0) || m1_wait !== !(acc && cand == 1)) begin
        miscompares++; $display("FAIL rnd_wait[%0d] got %b%b exp %b%b", cyc_i, m0_wait, m1_wait, !(acc && cand == 0), !(acc && cand == 1));
      end
      vectors++; if (m0_rdv !== e0 || m1_rdv !== e1) begin
        miscompares++; $display("FAIL rnd_rdv[%0d] got %b%b exp %b%b", cyc_i, m0_rdv, m1_rdv, e0, e1);
      end
      if (e0 || e1) begin
        vectors++; if ((e0 ? m0_rdata : m1_rdata) !== s_readdata) begin
          miscompares++; $display("FAIL rnd_rdata[%0d] got %h exp %h", cyc_i, e0 ? m0_rdata : m1_rdata, s_readdata);
        end
      end
      vectors++; if (rsp_err !== err) begin miscompares++; $display("FAIL rnd_rsp_err[%0d] got %b exp %b", cyc_i, rsp_err, err); end
      if (s_readdatavalid) begin
        if (q.size() > 0) void'(q.pop_front());
        else err = 1'b1;
      end
      if (acc && isrd) q.push_back(cand);
      if (acc) begin
        last = cand;
        act[cand] = 1'b0;
        locked = -1;
      end else begin
        locked = cand;
      end
      cyc();
    end
    idle_inputs();
  endtask

  initial begin
    srst = 1'b1;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_single_read();
    test_arbitration();
    test_hold();
    test_throttle();
    test_reset_outstanding();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
